// File: rtl/column_parity_stage_pkg.sv
// rtl/column_parity_stage_pkg.sv - shared constants and FSM encoding for the column parity mixer
package column_parity_stage_pkg;
  localparam int SLICE_W       = 25;
  localparam int GRID          = 5;
  localparam int DEPTH_DEFAULT = 64;

  // Column offsets of the two neighbour parities mixed into column x.
  localparam int X_PREV = 4;
  localparam int X_NEXT = 1;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_EMIT = 1'b1
  } state_t;
endpackage

// File: rtl/column_parity_stage_if.sv
// rtl/column_parity_stage_if.sv - valid/ready slice-line handshake bundle
interface column_parity_stage_if
  import column_parity_stage_pkg::*;
#(
  parameter int N = SLICE_W
) ();
  logic         valid;
  logic         ready;
  logic [N-1:0] line;

  modport master (output valid, output line, input ready);
  modport slave  (input valid, input line, output ready);
endinterface

// File: rtl/column_parity_stage_slice_parity.sv
// rtl/column_parity_stage_slice_parity.sv - column parities of one 5x5 slice (bit i -> x=i%5, y=i/5)
module column_parity_stage_slice_parity
  import column_parity_stage_pkg::*;
(
  input  logic [SLICE_W-1:0] line,
  output logic [GRID-1:0]    par
);
  always_comb begin
    par = '0;
    for (int y = 0; y < GRID; y++) begin
      for (int x = 0; x < GRID; x++) begin
        par[x] = par[x] ^ line[GRID*y + x];
      end
    end
  end
endmodule

// File: rtl/column_parity_stage.sv
// rtl/column_parity_stage.sv - block-buffered column parity mixer ahead of the lane permutation stage
// Optional COLUMN_PARITY_BYPASS_EN adds a per-block bypass input that passes slices through unmixed.
module column_parity_stage
  import column_parity_stage_pkg::*;
#(
  parameter int N     = SLICE_W,
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int CW    = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
`ifdef COLUMN_PARITY_BYPASS_EN
  input  logic                     bypass,
`endif
  column_parity_stage_if.slave     in_s,
  column_parity_stage_if.master    out_m,
  output logic                     busy,
  output logic                     done
);
  state_t          state;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   zp;
  logic [N-1:0]    line_mem [DEPTH];
  logic [GRID-1:0] par_mem  [DEPTH];
  logic [GRID-1:0] in_par;
  logic [GRID-1:0] d;
  logic [N-1:0]    mixed;
  logic            in_hs;
  logic            out_hs;
  logic            last;

  column_parity_stage_slice_parity u_slice_parity (
    .line (in_s.line),
    .par  (in_par)
  );

  assign in_s.ready  = (state == ST_LOAD);
  assign out_m.valid = (state == ST_EMIT);
  assign busy        = (state == ST_EMIT);
  assign in_hs       = in_s.valid & in_s.ready;
  assign out_hs      = out_m.valid & out_m.ready;
  assign last        = (cnt == CW'(DEPTH - 1));
  // Previous slice wraps from 0 to DEPTH-1 by plain CW-bit underflow.
  assign zp          = cnt - 1'b1;

  always_ff @(posedge clk) begin
    if (in_hs) begin
      line_mem[cnt] <= in_s.line;
      par_mem[cnt]  <= in_par;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_LOAD;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_LOAD: begin
          if (in_hs) begin
            cnt <= cnt + 1'b1;
            if (last) state <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (out_hs) begin
            cnt <= cnt + 1'b1;
            if (last) begin
              state <= ST_LOAD;
              done  <= 1'b1;
            end
          end
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

  always_comb begin
    d = '0;
    for (int x = 0; x < GRID; x++) begin
      d[x] = par_mem[cnt][(x + X_PREV) % GRID] ^ par_mem[zp][(x + X_NEXT) % GRID];
    end
  end

  // Column x of every row receives the same flip bit d[x].
  assign mixed = line_mem[cnt] ^ {GRID{d}};

`ifdef COLUMN_PARITY_BYPASS_EN
  logic bypass_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      bypass_q <= 1'b0;
    end else if (in_hs && cnt == '0) begin
      bypass_q <= bypass;
    end
  end

  assign out_m.line = out_m.valid ? (bypass_q ? line_mem[cnt] : mixed) : '0;
`else
  assign out_m.line = out_m.valid ? mixed : '0;
`endif
endmodule

// File: tb/tb_column_parity_stage.sv
// tb/tb_column_parity_stage.sv - self-checking bench for column_parity_stage
module tb_column_parity_stage;
  localparam int DEPTH = 64;
  localparam int N     = 25;

  logic clk = 1'b0;
  logic rst;
`ifdef COLUMN_PARITY_BYPASS_EN
  logic bypass = 1'b0;
`endif
  logic busy, done;

  column_parity_stage_if #(.N(N)) in_if ();
  column_parity_stage_if #(.N(N)) out_if ();

  column_parity_stage #(.DEPTH(DEPTH)) dut (
    .clk    (clk),
    .rst    (rst),
`ifdef COLUMN_PARITY_BYPASS_EN
    .bypass (bypass),
`endif
    .in_s   (in_if),
    .out_m  (out_if),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [N-1:0] blk [DEPTH];
  logic [N-1:0] got [DEPTH];

  typedef struct {
    string        name;
    int           in_z;
    logic [N-1:0] in_line;
    int           chk_z;
    logic [N-1:0] exp;
  } vec_t;
  vec_t vt [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit colpar(input int z, input int x);
    bit p = 1'b0;
    for (int y = 0; y < 5; y++) p ^= blk[z][5*y + x];
    return p;
  endfunction

  function automatic logic [N-1:0] model(input int z);
    logic [N-1:0] r;
    int zp = (z + DEPTH - 1) % DEPTH;
    for (int i = 0; i < N; i++) begin
      int x = i % 5;
      r[i] = blk[z][i] ^ colpar(z, (x + 4) % 5) ^ colpar(zp, (x + 1) % 5);
    end
    return r;
  endfunction

  task automatic load_block();
    for (int z = 0; z < DEPTH; z++) begin
      @(negedge clk);
      in_if.valid  = 1'b1;
      in_if.line   = blk[z];
      out_if.ready = 1'b0;
      chk($sformatf("load_in_ready z=%0d", z), 32'(in_if.ready), 32'd1);
    end
  endtask

  task automatic emit_block(input int hold_at, input int abort_at, input bit poke);
    for (int z = 0; z < DEPTH; z++) begin
      int nh;
      logic [31:0] r;
      if (z == abort_at) begin
        @(negedge clk);
        rst = 1'b1;
        in_if.valid = 1'b0;
        out_if.ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_in_ready", 32'(in_if.ready), 32'd1);
        chk("abort_out_valid", 32'(out_if.valid), 32'd0);
        chk("abort_out_line", 32'(out_if.line), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        @(negedge clk);
        chk("abort_done_next", 32'(done), 32'd0);
        return;
      end
      nh = (z == hold_at) ? 3 : 0;
      for (int k = 0; k <= nh; k++) begin
        @(negedge clk);
        out_if.ready = (k == nh);
        if (poke) begin
          r = $urandom;
          in_if.valid = r[31];
          in_if.line  = r[N-1:0];
        end else begin
          in_if.valid = 1'b0;
        end
        chk($sformatf("emit_in_ready z=%0d", z), 32'(in_if.ready), 32'd0);
        chk($sformatf("emit_out_valid z=%0d", z), 32'(out_if.valid), 32'd1);
        chk($sformatf("emit_out_line z=%0d k=%0d", z, k), 32'(out_if.line), 32'(model(z)));
        got[z] = out_if.line;
      end
    end
    @(negedge clk);
    out_if.ready = 1'b0;
    in_if.valid  = 1'b0;
    chk("end_out_valid", 32'(out_if.valid), 32'd0);
    chk("end_in_ready", 32'(in_if.ready), 32'd1);
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_done_pulse", 32'(done), 32'd1);
    @(negedge clk);
    chk("end_done_clear", 32'(done), 32'd0);
  endtask

  task automatic random_block();
    logic [31:0] r;
    for (int z = 0; z < DEPTH; z++) begin
      r = $urandom;
      blk[z] = r[N-1:0];
    end
  endtask

  initial begin
    vt[0] = '{"all_zero",        0,  25'h0000000, 0,  25'h0000000};
    vt[1] = '{"bit0_z0_out0",    0,  25'h0000001, 0,  25'h0210843};
    vt[2] = '{"bit0_z0_out1",    0,  25'h0000001, 1,  25'h1084210};
    vt[3] = '{"wrap_z63_out0",   63, 25'h0000001, 0,  25'h1084210};
    vt[4] = '{"wrap_z63_out63",  63, 25'h0000001, 63, 25'h0210843};
    vt[5] = '{"even_col_z5",     5,  25'h0000021, 5,  25'h0000021};

    rst = 1'b1;
    in_if.valid = 1'b0;
    in_if.line = '0;
    out_if.ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_in_ready", 32'(in_if.ready), 32'd1);
    chk("reset_out_valid", 32'(out_if.valid), 32'd0);
    chk("reset_out_line", 32'(out_if.line), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);

    for (int v = 0; v < 6; v++) begin
      for (int z = 0; z < DEPTH; z++) blk[z] = '0;
      blk[vt[v].in_z] = vt[v].in_line;
      load_block();
      emit_block(-1, -1, 1'b0);
      chk(vt[v].name, 32'(got[vt[v].chk_z]), 32'(vt[v].exp));
    end

    // Backpressure at slice 10 with in_valid pokes during EMIT.
    random_block();
    load_block();
    emit_block(10, -1, 1'b1);

    // Abort mid-EMIT, then a clean random block.
    random_block();
    load_block();
    emit_block(-1, 20, 1'b0);
    random_block();
    load_block();
    emit_block(-1, -1, 1'b0);

    for (int b = 0; b < 2; b++) begin
      random_block();
      load_block();
      emit_block(int'($urandom_range(0, DEPTH - 1)), -1, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/column_parity_stage.md
# column_parity_stage

Block-level column-parity mixer that sits directly upstream of the lane-permutation (swap) stage of the matrix encoder. It accepts one 5x5 state block as DEPTH consecutive 25-bit slice lines. Each slice is XORed with the parities of neighbouring columns from its own slice and the previous slice, wrapping from slice 0 to slice DEPTH-1. The mixed lines are then emitted in the same order to the permutation stage.

## Interface
Parameters:
- N, 25, slice line width (fixed 5x5 grid; bit i maps to x = i%5, y = i/5)
- DEPTH, 64, slices per block; must be a power of two and at least 2
- CW, $clog2(DEPTH), slice counter width

Ports:
- clk  input  1  single clock; all state updates on posedge
- rst  input  1  reset; synchronous and active-high
- in_valid  input  1  in_line holds a valid slice
- in_ready  output  1  block accepts a slice this cycle
- in_line  input  N  incoming slice line, slice order z = 0..DEPTH-1
- out_valid  output  1  out_line holds a valid mixed slice
- out_ready  input  1  downstream accepts out_line this cycle
- out_line  output  N  mixed slice line, slice order z = 0..DEPTH-1
- busy  output  1  block is in EMIT
- done  output  1  one-cycle pulse after the final output handshake of a block

## Operation
- Two-state FSM:
  - LOAD (reset state): in_ready=1, out_valid=0.
  - EMIT: in_ready=0, out_valid=1.
- LOAD
  - On each in_valid&&in_ready, store in_line into buf[cnt].
  - On the same handshake, store the column parities into par[cnt]: C[x] = XOR over y of in_line[5y+x], 5 bits.
  - cnt increments on each handshake.
  - The handshake at cnt=DEPTH-1 resets cnt to 0, and the FSM enters EMIT.
- EMIT
  - For z = cnt: D[x] = par[z][(x+4)%5] ^ par[(z-1) mod DEPTH][(x+1)%5].
  - out_line[5y+x] = buf[z][5y+x] ^ D[x].
  - out_line is combinational from registered state; it is 0 whenever out_valid=0.
  - On out_valid&&out_ready, cnt increments.
  - The handshake at cnt=DEPTH-1 resets cnt to 0, the FSM returns to LOAD, and done pulses the next cycle.
- Arithmetic:
  - x and y indices are modulo 5.
  - The slice index z-1 wraps modulo DEPTH; z=0 uses slice DEPTH-1, via natural CW-bit underflow.
- Inputs presented while in EMIT are ignored; in_ready=0 there, so no data is lost.

## Timing
- Reset values: state=LOAD, cnt=0, in_ready=1, out_valid=0, out_line=0, busy=0, done=0.
  - buf and par need not be reset; they are fully rewritten before use.
- Load throughput: one slice per cycle.
- The first out_valid is asserted the cycle after the DEPTH-th input handshake.
  - Minimum block latency from the first input to the first output is DEPTH cycles.
- Emit throughput: one slice per cycle with out_ready held high.
  - With out_ready low, out_line and cnt hold stable.
- The next block may begin loading the cycle after the final output handshake.
  - Input and output never overlap, so there is no simultaneous in/out handshake.
- rst asserted mid-LOAD or mid-EMIT aborts the block.
  - The next cycle shows reset values, and partial data is discarded.
  - done does not pulse for an aborted block.

## Configuration
- Macro: COLUMN_PARITY_BYPASS_EN.
- Defined:
  - Adds input port bypass (1 bit), sampled and latched on the first input handshake of each block.
  - When the latched value is 1, out_line = buf[z] unmodified, for use in permutation-only debug.
  - Block timing is identical in bypass and normal modes.
- Undefined:
  - No bypass port; mixing is always applied.

## Structure
- Shared package holds:
  - the slice width (25) and grid dimension (5);
  - the default DEPTH;
  - the FSM state enum (LOAD, EMIT);
  - x/y index helper constants.
- One natural sub-module: slice_parity (combinational, 25-bit in, 5-bit column parity out).
  - Instanced once on the input side.
  - The output-side neighbour parities come from the stored par registers.
- The counter and storage are local to this block.

## Test plan
- Reset, then an all-zero block of 64 slices -> 64 outputs of 0x0000000, then done pulses once.
- Single bit set: bit 0 in slice 0, all other slices zero:
  - slice 0 out = 0x0210843;
  - slice 1 out = 0x1084210;
  - all other slices out = 0.
- Wrap-around: bit 0 set in slice 63 only:
  - slice 0 out = 0x1084210;
  - slice 63 out = 0x0210843;
  - all others out = 0.
- Even-parity column: bits 0 and 5 set in slice 5 -> all outputs equal the inputs.
- Backpressure: hold out_ready low for 3 cycles at slice 10, with random data:
  - out_line and cnt are stable throughout;
  - the output sequence matches the reference model;
  - in_valid pulses during EMIT are not accepted.
- Reset mid-EMIT at slice 20:
  - the next cycle has in_ready=1, out_valid=0, no done pulse;
  - a following full block is processed correctly.
